rx_frame_ctrl: RTL

Receive-side controller that sits beside the UART Rx state machine and shift register inside the Rx core. It reads the FSM's one-hot state, bit index and bit-done strobe, then assembles each received byte LSB-first and checks parity and stop bit. Completed bytes and their error flags go into a small FIFO for the host. It also gates the FSM's enable and runs a watchdog that forces a resynchronisation when a frame stalls.

---
 rtl/rx_frame_pkg.sv | 19 +
 rtl/rx_byte_fifo.sv | 55 +++++
 rtl/rx_frame_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared constants and types for the receive frame controller.
//   - one-hot Rx FSM state encodings seen on State_i
//   - controller state enum (IDLE, ASSEMBLE, HOLD)
//   - FIFO entry layout {frame_err, parity_err, data[7:0]}
package rx_frame_pkg;
    localparam logic [4:0] ST_INTERVAL  = 5'b00001;
    localparam logic [4:0] ST_STARTBIT  = 5'b00010;
    localparam logic [4:0] ST_DATABITS  = 5'b00100;
    localparam logic [4:0] ST_PARITYBIT = 5'b01000;
    localparam logic [4:0] ST_STOPBIT   = 5'b10000;

    typedef enum logic [1:0] {IDLE, ASSEMBLE, HOLD} ctrl_state_t;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;
endpackage

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: first-word fall-through FIFO of received bytes with error flags.
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   i_wr, i_wdata push request and entry
//   i_rd          pop request, ignored while empty
//   o_rdata       head entry, zero while empty
//   o_valid       not empty
//   o_drop        push refused because full with no same-cycle pop
//   o_count       occupancy
module rx_byte_fifo
    import rx_frame_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr,
    input  rx_entry_t                  i_wdata,
    input  logic                       i_rd,
    output rx_entry_t                  o_rdata,
    output logic                       o_valid,
    output logic                       o_drop,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    rx_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_full, w_pop, w_push;

    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign o_valid = r_count != '0;
    assign w_pop   = i_rd & o_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_push  = i_wr & (~w_full | w_pop);
    assign o_drop  = i_wr & ~w_push;
    assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: assembles UART Rx bytes from the Rx FSM, checks parity/stop, queues them.
//   Optional watchdog enabled by defining RX_FRAME_TIMEOUT_EN (adds TIMEOUT_CYC parameter).
//   Inputs : clk, rst (async, active-high), enable_i, parity_en_i, parity_odd_i,
//            State_i (one-hot Rx FSM state), BitCounter_i, Bit_Synch_i, RxBit_i,
//            rd_i (pop), clr_i (clear sticky flags)
//   Outputs: p_Enable_o (Rx FSM enable), resync_o (FSM resync pulse),
//            valid_o/data_o/parity_err_o/frame_err_o (FIFO head), overrun_o,
//            timeout_o (sticky), count_o (FIFO occupancy)
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
`ifdef RX_FRAME_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic [4:0]                    State_i,
    input  logic [3:0]                    BitCounter_i,
    input  logic                          Bit_Synch_i,
    input  logic                          RxBit_i,
    input  logic                          rd_i,
    input  logic                          clr_i,
    output logic                          p_Enable_o,
    output logic                          resync_o,
    output logic                          valid_o,
    output logic [7:0]                    data_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic                          timeout_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    ctrl_state_t r_state, w_state;
    logic [7:0]  r_shreg;
    logic        r_acc, r_perr, r_in_stop, r_overrun, r_p_en;
    logic        w_commit, w_ferr, w_early, w_clear, w_drop, w_to;
    rx_entry_t   w_entry, w_head;

    // The FSM left STOPBIT without a stop strobe: the early resync still yields a byte.
    assign w_early = r_in_stop & (State_i != ST_STOPBIT);

    always_comb begin
        w_state  = r_state;
        w_commit = 1'b0;
        w_ferr   = 1'b0;
        if (w_to)
            w_state = HOLD;
        else if (r_state == IDLE)
            w_state = State_i == ST_STARTBIT ? ASSEMBLE : IDLE;
        else if (r_state == HOLD)
            w_state = State_i == ST_INTERVAL ? IDLE : HOLD;
        else if (!$onehot(State_i))
            w_state = IDLE;
        else if (w_early || (State_i == ST_STOPBIT && Bit_Synch_i)) begin
            w_commit = 1'b1;
            w_ferr   = w_early | ~RxBit_i;
            w_state  = State_i == ST_STARTBIT ? ASSEMBLE : IDLE;
        end else if (State_i == ST_INTERVAL)
            w_state = IDLE;
    end

    // Assembly registers restart whenever a frame is not being continued.
    assign w_clear = (r_state != ASSEMBLE) | (w_state != ASSEMBLE) | w_commit;
    assign w_entry = '{frame_err: w_ferr, parity_err: r_perr, data: r_shreg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_acc     <= 1'b0;
            r_perr    <= 1'b0;
            r_in_stop <= 1'b0;
            r_overrun <= 1'b0;
            r_p_en    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_in_stop <= (r_state == ASSEMBLE) & (w_state == ASSEMBLE) & (State_i == ST_STOPBIT) & ~w_commit;
            r_overrun <= clr_i ? 1'b0 : (w_drop ? 1'b1 : r_overrun);
            r_p_en    <= enable_i & (w_state != HOLD);
            if (w_clear) begin
                r_shreg <= '0;
                r_acc   <= 1'b0;
                r_perr  <= 1'b0;
            end else if (Bit_Synch_i && State_i == ST_DATABITS && !BitCounter_i[3]) begin
                r_shreg[BitCounter_i[2:0]] <= RxBit_i;
                r_acc                      <= r_acc ^ RxBit_i;
            end else if (Bit_Synch_i && State_i == ST_PARITYBIT)
                r_perr <= parity_en_i & (r_acc ^ RxBit_i ^ parity_odd_i);
        end
    end

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] r_wd;
    logic          r_timeout;

    // Fires on the TIMEOUT_CYC-th consecutive cycle without a strobe outside INTERVAL.
    assign w_to = (r_wd == WW'(TIMEOUT_CYC - 1)) & ~Bit_Synch_i & (State_i != ST_INTERVAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wd      <= (Bit_Synch_i || State_i == ST_INTERVAL || w_to) ? '0 : r_wd + WW'(1);
            r_timeout <= clr_i ? 1'b0 : (w_to ? 1'b1 : r_timeout);
        end
    end

    assign resync_o  = w_to;
    assign timeout_o = r_timeout;
`else
    assign w_to      = 1'b0;
    assign resync_o  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    rx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_commit),
        .i_wdata (w_entry),
        .i_rd    (rd_i),
        .o_rdata (w_head),
        .o_valid (valid_o),
        .o_drop  (w_drop),
        .o_count (count_o)
    );

    assign p_Enable_o   = r_p_en;
    assign data_o       = w_head.data;
    assign parity_err_o = w_head.parity_err;
    assign frame_err_o  = w_head.frame_err;
    assign overrun_o    = r_overrun;
endmodule
